// File: rtl/axis_pixel_unpacker.sv
// axis_pixel_unpacker: turns packed multi-pixel AXI-Stream words from the
// convolver into a one-pixel-per-beat stream, flagging the final pixel of
// each output column and counting completed columns.
module axis_pixel_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int NB_PIXEL   = 8,
  parameter int COL_PIXELS = 10,
  parameter int NB_COL_CNT = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [NB_PIXEL-1:0]   m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic [NB_COL_CNT-1:0] o_col_count
);

  localparam int PPW     = DATA_WIDTH / NB_PIXEL;
  localparam int IDX_W   = (PPW > 1) ? $clog2(PPW) : 1;
  // One extra bit so the lane count can represent PPW itself.
  localparam int LANE_W  = IDX_W + 1;
  localparam int COL_W   = $clog2(COL_PIXELS + 1);
  localparam int CNT_W   = (COL_W > LANE_W) ? COL_W : LANE_W;

  typedef enum logic {
    S_EMPTY,
    S_HOLD
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] word_q;
  logic [IDX_W-1:0]      lane_q;
  logic [LANE_W-1:0]     nlanes_q;
  logic [LANE_W-1:0]     nlanes_load;
  logic [CNT_W-1:0]      pix_cnt_q;
  logic [CNT_W-1:0]      pix_cnt_next;
  logic [CNT_W-1:0]      pix_remain;
  logic [NB_COL_CNT-1:0] col_cnt_q;
  logic                  hold;
  logic                  last_lane;
  logic                  col_end;
  logic                  s_ready_int;
  logic                  in_fire;
  logic                  out_fire;
  logic [NB_PIXEL-1:0]   lanes [PPW];

  // Valid lanes in a newly loaded word: a full word unless fewer pixels
  // remain in the current column, in which case only those low lanes count.
  function automatic logic [LANE_W-1:0] clamp_lanes(input logic [CNT_W-1:0] remain);
    if (remain >= CNT_W'(PPW))
      return LANE_W'(PPW);
    else
      return remain[LANE_W-1:0];
  endfunction

  for (genvar k = 0; k < PPW; k++) begin : g_lane
    assign lanes[k] = word_q[k*NB_PIXEL +: NB_PIXEL];
  end

  assign hold      = (state_q == S_HOLD);
  assign last_lane = ((LANE_W'(lane_q) + LANE_W'(1)) == nlanes_q);
  assign col_end   = (pix_cnt_q == CNT_W'(COL_PIXELS - 1));

  // Everything visible is forced low while reset is held, before the
  // registers have had an edge to clear.
  assign s_axis_ready = s_ready_int & ~axi_reset;
  assign m_axis_valid = hold & ~axi_reset;
  assign m_axis_data  = m_axis_valid ? lanes[lane_q] : '0;
  assign m_axis_last  = m_axis_valid & col_end;
  assign o_col_count  = axi_reset ? '0 : col_cnt_q;

  assign in_fire  = s_axis_valid & s_axis_ready;
  assign out_fire = m_axis_valid & m_axis_ready;

  // Column position after this cycle's output beat; a word loaded in the
  // same cycle sizes itself from this value.
  assign pix_cnt_next = !out_fire ? pix_cnt_q :
                        (col_end ? '0 : pix_cnt_q + CNT_W'(1));
  assign pix_remain   = CNT_W'(COL_PIXELS) - pix_cnt_next;
  assign nlanes_load  = clamp_lanes(pix_remain);

  // State register.
  always_ff @(posedge axi_clk) begin
    if (axi_reset)
      state_q <= S_EMPTY;
    else
      state_q <= state_d;
  end

  // Next state and input readiness; a word is taken while empty or in the
  // same cycle the last lane of the held word leaves, giving no bubbles.
  always_comb begin
    state_d     = state_q;
    s_ready_int = 1'b0;
    case (state_q)
      S_EMPTY: begin
        s_ready_int = 1'b1;
        if (s_axis_valid)
          state_d = S_HOLD;
      end
      S_HOLD: begin
        s_ready_int = m_axis_ready & last_lane;
        if (m_axis_ready && last_lane && !s_axis_valid)
          state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Held word, lane pointer and column/pixel counters.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      word_q    <= '0;
      lane_q    <= '0;
      nlanes_q  <= '0;
      pix_cnt_q <= '0;
      col_cnt_q <= '0;
    end else begin
      if (in_fire) begin
        word_q   <= s_axis_data;
        lane_q   <= '0;
        nlanes_q <= nlanes_load;
      end else if (out_fire && !last_lane) begin
        lane_q <= lane_q + IDX_W'(1);
      end
      pix_cnt_q <= pix_cnt_next;
      if (out_fire && col_end)
        col_cnt_q <= col_cnt_q + NB_COL_CNT'(1);
    end
  end

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// Self-checking bench for axis_pixel_unpacker: a queue-based pixel model fed
// from accepted words, checked every cycle, plus literal column expectations.
`timescale 1ns/1ps
module tb_axis_pixel_unpacker;

  localparam int DATA_WIDTH = 32;
  localparam int NB_PIXEL   = 8;
  localparam int COL_PIXELS = 10;
  localparam int NB_COL_CNT = 16;
  localparam int PPW        = DATA_WIDTH / NB_PIXEL;

  logic                  axi_clk = 1'b0;
  logic                  axi_reset = 1'b1;
  logic                  s_axis_valid = 1'b0;
  logic [DATA_WIDTH-1:0] s_axis_data = '0;
  logic                  s_axis_ready;
  logic                  m_axis_valid;
  logic [NB_PIXEL-1:0]   m_axis_data;
  logic                  m_axis_last;
  logic                  m_axis_ready = 1'b1;
  logic [NB_COL_CNT-1:0] o_col_count;

  axis_pixel_unpacker #(
    .DATA_WIDTH(DATA_WIDTH),
    .NB_PIXEL  (NB_PIXEL),
    .COL_PIXELS(COL_PIXELS),
    .NB_COL_CNT(NB_COL_CNT)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset   (axi_reset),
    .s_axis_valid(s_axis_valid),
    .s_axis_data (s_axis_data),
    .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid),
    .m_axis_data (m_axis_data),
    .m_axis_last (m_axis_last),
    .m_axis_ready(m_axis_ready),
    .o_col_count (o_col_count)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } pix_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } log_t;

  int              n_checks = 0;
  int              n_fail = 0;
  pix_t            exp_q[$];
  log_t            out_log[$];
  int              model_pos = 0;
  logic [15:0]     exp_cols = '0;
  int              cyc = 0;
  int              rdy_mode = 0;
  logic            prev_stall = 1'b0;
  logic [7:0]      prev_data = '0;
  logic            prev_last = 1'b0;
  logic [7:0]      col_ref [COL_PIXELS];
  logic [31:0]     col_words [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle compare, sampled on the falling edge.
  always @(negedge axi_clk) begin
    int   n;
    pix_t p;
    cyc++;
    if (axi_reset) begin
      chk("rst_s_ready", 32'(s_axis_ready), 32'd0);
      chk("rst_m_valid", 32'(m_axis_valid), 32'd0);
      chk("rst_m_data",  32'(m_axis_data),  32'd0);
      chk("rst_m_last",  32'(m_axis_last),  32'd0);
      chk("rst_col_cnt", 32'(o_col_count),  32'd0);
      exp_q.delete();
      model_pos  = 0;
      exp_cols   = '0;
      prev_stall = 1'b0;
    end else begin
      chk("m_valid", 32'(m_axis_valid), 32'(exp_q.size() > 0));
      chk("s_ready", 32'(s_axis_ready),
          32'((exp_q.size() == 0) || (m_axis_ready && exp_q.size() == 1)));
      chk("col_count", 32'(o_col_count), 32'(exp_cols));
      if (exp_q.size() > 0) begin
        chk("m_data", 32'(m_axis_data), 32'(exp_q[0].data));
        chk("m_last", 32'(m_axis_last), 32'(exp_q[0].last));
      end
      if (prev_stall) begin
        chk("stall_data", 32'(m_axis_data), 32'(prev_data));
        chk("stall_last", 32'(m_axis_last), 32'(prev_last));
      end
      prev_stall = m_axis_valid && !m_axis_ready;
      prev_data  = m_axis_data;
      prev_last  = m_axis_last;
      if (m_axis_valid && m_axis_ready) begin
        out_log.push_back('{m_axis_data, m_axis_last, cyc});
        if (exp_q.size() > 0) begin
          if (exp_q[0].last)
            exp_cols = exp_cols + 16'd1;
          void'(exp_q.pop_front());
        end
      end
      if (s_axis_valid && s_axis_ready) begin
        n = COL_PIXELS - model_pos;
        if (n > PPW)
          n = PPW;
        for (int k = 0; k < n; k++) begin
          p.data = s_axis_data[k*8 +: 8];
          p.last = (model_pos + k == COL_PIXELS - 1);
          exp_q.push_back(p);
        end
        model_pos = (model_pos + n) % COL_PIXELS;
      end
    end
  end

  // Downstream ready pattern: 0 = always, 1 = toggle, other = random.
  initial begin
    forever begin
      @(posedge axi_clk);
      #1;
      case (rdy_mode)
        0:       m_axis_ready = 1'b1;
        1:       m_axis_ready = ~m_axis_ready;
        default: m_axis_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int   budget;
    logic got;
    budget = 0;
    got    = 1'b0;
    s_axis_valid = 1'b1;
    s_axis_data  = w;
    while (!got && budget < 200) begin
      @(negedge axi_clk);
      got = s_axis_ready;
      @(posedge axi_clk);
      #1;
      budget++;
    end
    s_axis_valid = 1'b0;
    chk("send_accept", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || m_axis_valid) && budget < 400) begin
      step(1);
      budget++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    step(2);
  endtask

  task automatic do_reset(input int n);
    axi_reset    = 1'b1;
    s_axis_valid = 1'b1;
    s_axis_data  = 32'hDEADBEEF;
    step(n);
    axi_reset    = 1'b0;
    s_axis_valid = 1'b0;
    @(negedge axi_clk);
    chk("post_rst_ready", 32'(s_axis_ready), 32'd1);
    @(posedge axi_clk);
    #1;
    out_log.delete();
  endtask

  task automatic check_col_log(input string tag, input bit consecutive);
    chk({tag, "_count"}, 32'(out_log.size()), 32'(COL_PIXELS));
    for (int i = 0; i < COL_PIXELS && i < out_log.size(); i++) begin
      chk({tag, "_data"}, 32'(out_log[i].data), 32'(col_ref[i]));
      chk({tag, "_last"}, 32'(out_log[i].last), 32'(i == COL_PIXELS - 1));
      if (consecutive)
        chk({tag, "_no_bubble"}, 32'(out_log[i].cyc), 32'(out_log[0].cyc + i));
    end
  endtask

  initial begin
    int budget;
    col_words[0] = 32'h83828100;
    col_words[1] = 32'h89888700;
    col_words[2] = 32'h8F8E8D00;
    col_ref = '{8'h00, 8'h81, 8'h82, 8'h83, 8'h00, 8'h87, 8'h88, 8'h89, 8'h00, 8'h8D};

    @(posedge axi_clk);
    #1;
    do_reset(3);

    // Single word: four pixels, no last.
    rdy_mode = 0;
    send_word(32'h83828100);
    drain();
    chk("single_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      chk("single_data", 32'(out_log[i].data), 32'(col_ref[i]));
      chk("single_last", 32'(out_log[i].last), 32'd0);
    end

    // Full column back-to-back.
    do_reset(2);
    for (int i = 0; i < 3; i++)
      send_word(col_words[i]);
    drain();
    check_col_log("fullcol", 1'b1);
    chk("fullcol_cols", 32'(o_col_count), 32'd1);

    // Same column under toggling backpressure.
    do_reset(2);
    rdy_mode = 1;
    for (int i = 0; i < 3; i++)
      send_word(col_words[i]);
    drain();
    check_col_log("bp", 1'b0);
    chk("bp_cols", 32'(o_col_count), 32'd1);

    // Input gaps over two columns.
    do_reset(2);
    rdy_mode = 0;
    for (int w = 0; w < 6; w++) begin
      send_word($urandom);
      step(7);
    end
    drain();
    chk("gap_count", 32'(out_log.size()), 32'd20);
    for (int i = 0; i < 20 && i < out_log.size(); i++)
      chk("gap_last", 32'(out_log[i].last), 32'(i == 9 || i == 19));
    chk("gap_cols", 32'(o_col_count), 32'd2);

    // Reset after six pixels of a column, then a fresh column.
    do_reset(2);
    send_word(32'h44332211);
    send_word(32'h88776655);
    budget = 0;
    while (out_log.size() < 6 && budget < 100) begin
      step(1);
      budget++;
    end
    chk("midrst_six", 32'(out_log.size() >= 6), 32'd1);
    do_reset(2);
    for (int i = 0; i < 3; i++)
      send_word(col_words[i]);
    drain();
    check_col_log("midrst", 1'b1);
    chk("midrst_cols", 32'(o_col_count), 32'd1);

    // Randomized traffic with random backpressure and gaps.
    rdy_mode = 2;
    for (int w = 0; w < 300; w++) begin
      send_word($urandom);
      step($urandom_range(0, 3));
    end
    drain();
    chk("rand_cols", 32'(o_col_count), 32'(exp_cols));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pixel_unpacker.md
# axis_pixel_unpacker

Stream unpacker on the output side of the stream convolver. It accepts the convolver's 32-bit AXI-Stream words, each holding packed 8-bit pixels. It emits them as a one-pixel-per-beat AXI-Stream toward the DMA/microprocessor path, marking the last pixel of every output column with `m_axis_last` and counting completed columns. It is the counterpart of the pixel packing done by software on the convolver's input stream.

## Interface
Parameters:
- `DATA_WIDTH`, 32, input word width; must be a multiple of `NB_PIXEL`.
- `NB_PIXEL`, 8, pixel width; pixels per word `PPW = DATA_WIDTH/NB_PIXEL` (4).
- `COL_PIXELS`, 10, valid pixels per output column (`IMAGE_HEIGHT-2` for a 3x3 kernel); range 1..1023.
- `NB_COL_CNT`, 16, width of the completed-column counter.

Ports:
- `axi_clk`  in  1  clock, all logic on rising edge.
- `axi_reset`  in  1  synchronous, active-high reset.
- `s_axis_valid`  in  1  input word valid.
- `s_axis_data`  in  DATA_WIDTH  packed pixels; lane k = bits [k*NB_PIXEL +: NB_PIXEL], lane 0 first.
- `s_axis_ready`  out  1  unpacker can take a word.
- `m_axis_valid`  out  1  output pixel valid.
- `m_axis_data`  out  NB_PIXEL  current pixel.
- `m_axis_last`  out  1  high with the final pixel of a column.
- `m_axis_ready`  in  1  downstream accepts pixel.
- `o_col_count`  out  NB_COL_CNT  completed columns since reset; wraps modulo 2^NB_COL_CNT.

## Operation
- Words per column: `WPC = ceil(COL_PIXELS/PPW)`. The last word of a column carries `COL_PIXELS - (WPC-1)*PPW` valid lanes, lowest lanes first. Higher lanes in that word are discarded, never emitted.
- Registers: `word_q`, `lane_q` (0..PPW-1), `nlanes_q` (valid lanes in held word), `pix_cnt_q` (0..COL_PIXELS-1), `col_cnt_q`.
- States:
  - EMPTY: no word held; `m_axis_valid`=0, `s_axis_ready`=1.
  - HOLD: word held; `m_axis_valid`=1, `m_axis_data`=lane `lane_q` of `word_q`.
- Transfers: input transfer = `s_axis_valid & s_axis_ready`; output transfer = `m_axis_valid & m_axis_ready`.
- EMPTY -> HOLD on input transfer:
  - `word_q` is loaded, `lane_q`=0.
  - `nlanes_q`=PPW, or the partial count if this word completes the column (derived from `pix_cnt_q`).
- HOLD, output transfer, `lane_q < nlanes_q-1`: `lane_q` increments.
- HOLD, output transfer on the last lane:
  - With an input transfer in the same cycle: stay HOLD, reload the word.
  - Otherwise: go to EMPTY.
- `s_axis_ready` = EMPTY, or (HOLD & `m_axis_ready` & `lane_q == nlanes_q-1`). This is combinational and gives zero-bubble back-to-back words.
- `pix_cnt_q` increments on every output transfer. It wraps to 0 on the pixel where it equals COL_PIXELS-1.
- `m_axis_last` = HOLD & (`pix_cnt_q == COL_PIXELS-1`).
- On an output transfer with `m_axis_last`=1, `col_cnt_q` increments, wrapping at 2^NB_COL_CNT.
- Stalls: while `m_axis_valid`=1 and `m_axis_ready`=0, `m_axis_data` and `m_axis_last` hold stable, and `s_axis_ready`=0 unless EMPTY.
- Input gaps (as with the convolver's intermittent valid): on last-lane output the block drops to EMPTY. `m_axis_valid` stays 0 until the next word arrives, and column position is preserved.

## Timing
- Reset (synchronous, sampled at a rising edge while `axi_reset`=1):
  - State EMPTY, `word_q`=0, counters 0.
  - Outputs: `m_axis_valid`=0, `m_axis_data`=0, `m_axis_last`=0, `o_col_count`=0, `s_axis_ready`=0 while `axi_reset`=1.
  - `s_axis_ready`=1 in the first cycle after reset deasserts.
- Reset mid-column: the held word and partial column are discarded, and the next word is treated as lane 0 of pixel 0.
- Latency: a word accepted at edge N presents lane 0 from edge N (visible cycle N+1).
- Throughput: with `s_axis_valid` and `m_axis_ready` held high, one pixel per cycle. A full word sustains PPW cycles and a partial word `nlanes_q` cycles.
- `PPW` divides `COL_PIXELS` (e.g. 8): no partial word; `nlanes_q`=PPW always.
- `COL_PIXELS` < PPW: every word is a partial word.

## Test plan
- Reset: hold `axi_reset` 3 cycles with `s_axis_valid`=1 -> `s_axis_ready`=0, `m_axis_valid`=0, `o_col_count`=0. One cycle after release, `s_axis_ready`=1.
- Single word 0x83828100 (lanes 0,129,130,131), COL_PIXELS=10, `m_axis_ready`=1 -> pixels 0,129,130,131 on 4 consecutive cycles, `m_axis_last`=0 throughout, then `m_axis_valid`=0.
- Full column: words 0x83828100, 0x89888700, 0x8F8E8D00 back-to-back -> exactly 10 pixels, no bubbles.
  - `m_axis_last`=1 only on the 10th pixel (value 0x8D).
  - 0x8F and 0x8E are never emitted.
  - `o_col_count`=1.
- Backpressure: toggle `m_axis_ready` every cycle during the full-column test -> same 10-pixel sequence, data stable while stalled, `s_axis_ready` high only on the cycle accepting the last lane or when EMPTY.
- Input gaps: `s_axis_valid` high 1 of every 8 cycles over 2 columns -> 20 pixels in order, `m_axis_last` on pixels 10 and 20, `o_col_count`=2.
- Reset mid-column after 6 pixels, then a fresh column -> next pixel is lane 0 of the new word, `m_axis_last` after 10 further pixels, `o_col_count`=1.
